// File: rtl/mem_access_unit_if.sv
// Bundles the processor-side request/response signals and the data-RAM port of mem_access_unit.
// The slave modport is the unit itself; the master modport is its environment (MEM stage plus RAM).
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        busy;
    logic [11:0] ram_addr;
    logic [31:0] ram_data;
    logic        ram_mW;
    logic [31:0] ram_rdata;

    modport slave (
        input  req, we, size, sign_ext, addr, wdata, ram_rdata,
        output rdata, done, err, busy, ram_addr, ram_data, ram_mW
    );

    modport master (
        output req, we, size, sign_ext, addr, wdata, ram_rdata,
        input  rdata, done, err, busy, ram_addr, ram_data, ram_mW
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end for a word-addressed data RAM with registered read data.
// Handles byte/halfword/word sizes, load extension, read-modify-write sub-word stores and misalignment.
module mem_access_unit #(
    parameter int READ_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [13:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        misaligned_in;
    logic [31:0] wr_word;

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] off,
                                                 input logic [1:0] sz, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        if (sz[1])
            r = w;
        else if (sz[0])
            r = {{16{sx & h[15]}}, h};
        else
            r = {{24{sx & b[7]}}, b};
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                                input logic [1:0] off, input logic [1:0] sz);
        logic [31:0] r;
        r = w;
        if (sz[1]) begin
            r = d;
        end else if (sz[0]) begin
            if (off[1])
                r[31:16] = d[15:0];
            else
                r[15:0] = d[15:0];
        end else begin
            case (off)
                2'd0:    r[7:0]   = d[7:0];
                2'd1:    r[15:8]  = d[7:0];
                2'd2:    r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end
        return r;
    endfunction

    // size 2 and 3 are both word accesses, so size[1] alone selects the word rule
    assign misaligned_in = bus.size[1] ? (bus.addr[1:0] != 2'b00)
                         : (bus.size[0] & bus.addr[0]);

    assign wr_word = store_merge(buf_q, wdata_q, addr_q[1:0], size_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    size_d  = bus.size;
                    sext_d  = bus.sign_ext;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    if (misaligned_in) begin
                        state_d = DONE;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else if (bus.we && bus.size[1]) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            READ: begin
                if (cnt_q == 2'd0) begin
                    buf_d = bus.ram_rdata;
                    if (we_q) begin
                        state_d = WRITE;
                    end else begin
                        state_d = DONE;
                        rdata_d = load_extract(bus.ram_rdata, addr_q[1:0], size_q, sext_q);
                        err_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            WRITE: begin
                state_d = DONE;
                err_d   = 1'b0;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.ram_addr = addr_q[13:2];
    assign bus.ram_mW   = (state_q == WRITE);
    assign bus.ram_data = (state_q == WRITE) ? wr_word : '0;
    assign bus.rdata    = rdata_q;
    assign bus.err      = err_q;
    assign bus.done     = (state_q == DONE);
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the processor MEM stage and the word-addressed data RAM (12-bit word address, 32-bit data, registered read output, write enable `mW`).
- Converts byte-addressed load/store requests into RAM accesses:
  - word, halfword and byte sizes;
  - sign/zero extension on loads;
  - read-modify-write for sub-word stores.
- Detects misaligned accesses.
- Drives `busy` so the pipeline stalls while an access is in flight.

Parameters:
- READ_LAT, 1, cycles from a stable `ram_addr` to valid `ram_rdata` (RAM output register); legal range 1..3.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  14  byte address; [13:2] = word address, [1:0] = byte offset.
- wdata  in  32  store data, right-aligned.
- ram_rdata  in  32  RAM DataOut.
- ram_addr  out  12  RAM word address.
- ram_data  out  32  RAM write data.
- ram_mW  out  1  RAM write enable.
- rdata  out  32  load result.
- done  out  1  one-cycle completion pulse.
- err  out  1  misalignment flag; valid with `done`.
- busy  out  1  high while state != IDLE.

Behaviour:
- **Reset** (asynchronous, immediate): state = IDLE. All outputs are 0: ram_addr, ram_data, ram_mW, rdata, done, err, busy. Reset mid-access aborts it; `ram_mW` drops without waiting for a clock. No partial write is completed after reset release.
- **Request latching:** at acceptance (IDLE and req=1 at a posedge), latch we, size, sign_ext, addr, wdata.
  - `ram_addr` = addr[13:2] from the next cycle and is held until return to IDLE.
  - `req` is ignored while busy.
- **State machine:** IDLE, READ, WRITE, DONE.
  - IDLE: misaligned request → DONE. Word store → WRITE. Load or sub-word store → READ.
  - READ: a counter runs for READ_LAT cycles. On the last cycle, `ram_rdata` is captured into a word buffer.
    - Load → DONE.
    - Sub-word store → WRITE.
  - WRITE: `ram_mW` = 1 for exactly one cycle; `ram_data` = merged word → DONE.
  - DONE: `done` = 1 for one cycle → IDLE. A new `req` may be accepted on the posedge that leaves DONE? No: it is sampled on the following IDLE cycle.
- **Latency** (acceptance edge to `done` cycle):
  - word store: 2 cycles;
  - load: READ_LAT + 1 cycles;
  - sub-word store: READ_LAT + 2 cycles;
  - misaligned: 1 cycle.
- **Alignment:**
  - halfword requires addr[0] = 0;
  - word requires addr[1:0] = 0;
  - byte is always aligned.
  - Misaligned access: err = 1 and rdata = 0 with `done`; no RAM write occurs.
  - `err` is 0 on every aligned completion.
- **Lanes:** little-endian; byte k occupies bits [8k+7:8k], k = addr[1:0]. Halfword at offset 0 occupies [15:0]; at offset 2 it occupies [31:16].
- **Load extract:** select the lane, shift it to bit 0, then extend to 32 bits per `sign_ext`. Word loads pass through unchanged.
- **Store merge:** the buffered word with only the addressed lane replaced by wdata[7:0] or wdata[15:0]; all other bits are preserved.
- **Output hold:** `rdata` and `err` hold their value after `done` until the next completion.

Test Plan:
- **Word store then load:** sw addr 0x0010, wdata 0xDEADBEEF → ram_mW high one cycle with ram_addr = 0x004, done 2 cycles after acceptance. lw 0x0010 → rdata = 0xDEADBEEF, err = 0, done at READ_LAT + 1.
- **Byte store RMW:** RAM word 0x004 = 0x11223344; sb addr 0x0012, wdata 0xAA → single write of 0x11AA3344. lb 0x0012 sign_ext=1 → 0xFFFFFFAA; lbu → 0x000000AA.
- **Halfword:** sh addr 0x0012, wdata 0x8001 on 0x11223344 → 0x80013344. lh 0x0012 → 0xFFFF8001; lhu → 0x00008001.
- **Misalignment:** lw 0x0011, sh 0x0013 → done one cycle after acceptance, err = 1, rdata = 0, ram_mW never asserted, RAM contents unchanged.
- **Busy handling:** hold req = 1 continuously across a lb → a second access is not accepted until the cycle after DONE. busy is high for exactly READ_LAT + 1 cycles.
- **Reset mid-RMW:** assert rst during READ of an sb → busy, ram_mW, done drop immediately. After release there is no write to the RAM and state = IDLE. Repeat with READ_LAT = 3.
